fmesh_route_reg: RTL and testbench
==================================

# fmesh_route_reg

Per-input-port, per-VC route computation register for the fmesh router. It captures each header flit's destination endpoint address and computes the 4-bit coded destination port {x,y,a,b} plus the local-port number. It holds both per VC until the packet's tail leaves. Sits directly upstream of fmesh_destp_generator, which consumes `dest_port_coded` / `endp_localp_num` for the selected VC.

## Interface
Parameters:
- V, 4, number of virtual channels per input port
- ROUTE_NAME, "XY", routing algorithm name; "XY" or adaptive names
- ROUTE_TYPE, "DETERMINISTIC", "DETERMINISTIC" or "FULL_ADAPTIVE"/"PAR_ADAPTIVE"
- DSTPw, 4, coded destination-port width; fixed at 4
- PLw, 3, local-port-number width; ≥ log2(5+NL-1)

NX, NY, NL and EAw come from pronoc_pkg.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  router clock
- reset  in  1  synchronous, active-high
- current_x  in  log2(NX)  this router's X
- current_y  in  log2(NY)  this router's Y
- hdr_wr  in  1  header flit written this cycle
- hdr_vc  in  V  one-hot VC of the header
- hdr_dest_e_addr  in  EAw  destination endpoint address {ep,ey,ex}
- tail_rd  in  V  per-VC: tail flit left the input buffer this cycle
- route_valid  out  V  per-VC: a route is held
- dest_port_coded_all  out  V*DSTPw  per-VC {x,y,a,b}; VC v at [v*4 +: 4]
- endp_localp_num_all  out  V*PLw  per-VC local port number
- addr_err  out  1  sticky: an invalid endpoint address was seen
- hdr_conflict_err  out  1  sticky: header arrived on a VC already holding a route

## Operation
- Decode `hdr_dest_e_addr` into ex, ey, ep, valid.
  - valid = ex≤NX-1 & ey≤NY-1 & ep≤P-1, where P=5+NL-1.
- Coding fields:
  - x = (ex > current_x): east when 1, west when 0.
  - y = (ey < current_y): north when 1, south when 0.
  - dx = (ex ≠ current_x); dy = (ey ≠ current_y).
- Field a/b:
  - When ROUTE_TYPE=="DETERMINISTIC": {a,b} = dx ? 10 : (dy ? 01 : 00).
  - Otherwise: {a,b} = {dx,dy}.
- endp_localp_num = ep when !dx & !dy, else 0.
  - Width-truncate or zero-extend ep to PLw.
- Invalid address:
  - Store code 4'b0000 and localp 0, so the packet is drained to local port 0.
  - Set addr_err; it stays set until reset.
- Per-VC state, two states: IDLE (route_valid=0) and ROUTED (route_valid=1).
  - IDLE → ROUTED on hdr_wr & hdr_vc[v].
  - ROUTED → IDLE on tail_rd[v].
  - In ROUTED, a header on the same VC without a tail_rd that cycle sets hdr_conflict_err and overwrites the stored route.
- Simultaneous events on one VC:
  - hdr_wr & tail_rd in the same cycle: the header wins. The new route is loaded and route_valid stays 1; this covers single-flit and back-to-back packets.
  - A tail_rd in the same cycle as the header does not raise hdr_conflict_err.
- hdr_vc handling:
  - hdr_vc==0 with hdr_wr: no effect.
  - Multi-hot hdr_vc: every selected VC loads the same route; this is a protocol violation and is not flagged.
- tail_rd[v] in IDLE: no effect.

## Timing
- Reset value: route_valid=0, all coded/localp fields=0, addr_err=0, hdr_conflict_err=0.
- Reset mid-packet discards all routes at the next edge.
- Latency: hdr_wr at edge t makes the route visible on the outputs after edge t, i.e. from cycle t+1. It is registered; there is no combinational path from hdr_dest_e_addr to the outputs.
- Stored fields change only on a header load for that VC. Outputs are stable while ROUTED.
- route_valid falls the cycle after tail_rd.
- The error flags assert the cycle after the offending header.

## Structure
- pronoc_pkg supplies NX, NY, NL, EAw and log2.
- Add the localparam P_PORTS = 5+NL-1 to pronoc_pkg.
- Sub-module: instantiate the existing fmesh_endp_addr_decode once, on hdr_dest_e_addr.
- Route coding is a combinational function, fmesh_code_route, placed in pronoc_pkg so look-ahead routing can reuse it.
- Per-VC registers are built with a generate loop over V.

## Test plan
The bench runs with NX=NY=4, NL=1, P=5, current=(1,1).

1. DETERMINISTIC, header VC0 to (ex=3,ey=1,ep=0) -> cycle+1: route_valid=0001, code VC0=4'b1010, localp=0.
2. DETERMINISTIC, header VC1 to (3,3) -> code 4'b1010. Repeat with ROUTE_TYPE="FULL_ADAPTIVE" -> 4'b1011. Header to (1,0) -> 4'b0101 in both modes.
3. Header VC2 to (1,1,ep=3) -> code 4'b0000, localp=3. tail_rd[2] next cycle -> route_valid[2]=0 one cycle later.
4. Header to ep=6 (exceeds P-1=4) -> code 0000, localp 0, addr_err=1 and held through 20 idle cycles. Reset -> addr_err=0.
5. VC0 ROUTED. Same-cycle tail_rd[0] and header to (0,1) -> route_valid[0] stays 1, code=4'b0010, hdr_conflict_err=0. A further header on VC0 without tail_rd -> hdr_conflict_err=1.
6. Routes held on all four VCs, then reset asserted for one cycle -> all outputs 0. tail_rd pulses while IDLE -> no change.

Source files
------------

// File: rtl/pronoc_pkg.sv
// Shared fmesh/pronoc constants, per-VC route state encoding and the
// route-coding function reused by look-ahead routing.
package pronoc_pkg;

    localparam int NX = 4;
    localparam int NY = 4;
    localparam int NL = 1;

    function automatic int log2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    localparam int P_PORTS = 5 + NL - 1;
    localparam int Xw      = log2(NX);
    localparam int Yw      = log2(NY);
    localparam int Pw      = log2(P_PORTS);
    localparam int EAw     = Xw + Yw + Pw;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ROUTED = 1'b1
    } vc_state_e;

    // {x,y,a,b}: x=east, y=north; a/b flag the productive dimension(s).
    // Deterministic XY picks X first, adaptive exposes both.
    function automatic logic [3:0] fmesh_code_route(
        input logic [Xw-1:0] ex,
        input logic [Yw-1:0] ey,
        input logic [Xw-1:0] cx,
        input logic [Yw-1:0] cy,
        input logic          det
    );
        logic x, y, dx, dy;
        logic [1:0] ab;
        x  = (ex > cx);
        y  = (ey < cy);
        dx = (ex != cx);
        dy = (ey != cy);
        if (det) ab = dx ? 2'b10 : (dy ? 2'b01 : 2'b00);
        else     ab = {dx, dy};
        return {x, y, ab};
    endfunction

endpackage

// File: rtl/fmesh_route_reg_if.sv
// Header/tail strobes in, per-VC held routes and sticky error flags out.
interface fmesh_route_reg_if #(
    parameter int V     = 4,
    parameter int DSTPw = 4,
    parameter int PLw   = 3
);
    import pronoc_pkg::*;

    logic                 hdr_wr;
    logic [V-1:0]         hdr_vc;
    logic [EAw-1:0]       hdr_dest_e_addr;
    logic [V-1:0]         tail_rd;
    logic [V-1:0]         route_valid;
    logic [V*DSTPw-1:0]   dest_port_coded_all;
    logic [V*PLw-1:0]     endp_localp_num_all;
    logic                 addr_err;
    logic                 hdr_conflict_err;

    modport master (
        output hdr_wr, hdr_vc, hdr_dest_e_addr, tail_rd,
        input  route_valid, dest_port_coded_all, endp_localp_num_all,
               addr_err, hdr_conflict_err
    );

    modport slave (
        input  hdr_wr, hdr_vc, hdr_dest_e_addr, tail_rd,
        output route_valid, dest_port_coded_all, endp_localp_num_all,
               addr_err, hdr_conflict_err
    );
endinterface

// File: rtl/fmesh_endp_addr_decode.sv
// Splits an endpoint address {ep,ey,ex} into fields and range-checks them.
module fmesh_endp_addr_decode
    import pronoc_pkg::*;
(
    input  logic [EAw-1:0] i_e_addr,
    output logic [Xw-1:0]  o_ex,
    output logic [Yw-1:0]  o_ey,
    output logic [Pw-1:0]  o_ep,
    output logic           o_valid
);
    assign o_ex = i_e_addr[Xw-1:0];
    assign o_ey = i_e_addr[Xw +: Yw];
    assign o_ep = i_e_addr[Xw+Yw +: Pw];

    assign o_valid = (int'(o_ex) < NX) && (int'(o_ey) < NY) && (int'(o_ep) < P_PORTS);
endmodule

// File: rtl/fmesh_route_reg.sv
// Per-VC route register: latches the coded destination port and local port
// of each header and holds them until that packet's tail leaves.
module fmesh_route_reg
    import pronoc_pkg::*;
#(
    parameter int V          = 4,
    parameter     ROUTE_NAME = "XY",
    parameter     ROUTE_TYPE = "DETERMINISTIC",
    parameter int DSTPw      = 4,
    parameter int PLw        = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [Xw-1:0] current_x,
    input  logic [Yw-1:0] current_y,
    fmesh_route_reg_if.slave rt
);
    localparam logic DET = (ROUTE_TYPE == "DETERMINISTIC");

    logic [Xw-1:0]    w_ex;
    logic [Yw-1:0]    w_ey;
    logic [Pw-1:0]    w_ep;
    logic             w_valid;
    logic [DSTPw-1:0] w_code;
    logic [PLw-1:0]   w_lp;
    logic             w_local;
    logic [V-1:0]     w_conflict;
    logic             r_addr_err;
    logic             r_hdr_conflict_err;

    fmesh_endp_addr_decode u_decode (
        .i_e_addr (rt.hdr_dest_e_addr),
        .o_ex     (w_ex),
        .o_ey     (w_ey),
        .o_ep     (w_ep),
        .o_valid  (w_valid)
    );

    // Invalid addresses are steered to local port 0 so the packet still drains.
    assign w_local = (w_ex == current_x) && (w_ey == current_y);
    assign w_code  = w_valid ? DSTPw'(fmesh_code_route(w_ex, w_ey, current_x, current_y, DET)) : '0;
    assign w_lp    = (w_valid && w_local) ? PLw'(w_ep) : '0;

    for (genvar v = 0; v < V; v++) begin : g_vc
        vc_state_e        r_state;
        vc_state_e        w_state_nxt;
        logic [DSTPw-1:0] r_code;
        logic [PLw-1:0]   r_lp;
        logic             w_load;
        logic             w_clash;

        assign w_load = rt.hdr_wr & rt.hdr_vc[v];

        // A header always wins over a same-cycle tail, so back-to-back
        // packets keep the VC routed without a bubble.
        always_comb begin
            w_state_nxt = r_state;
            w_clash     = 1'b0;
            case (r_state)
                ST_IDLE:   if (w_load) w_state_nxt = ST_ROUTED;
                ST_ROUTED: begin
                    if (w_load) begin
                        w_state_nxt = ST_ROUTED;
                        w_clash     = ~rt.tail_rd[v];
                    end else if (rt.tail_rd[v]) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default:   w_state_nxt = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= ST_IDLE;
                r_code  <= '0;
                r_lp    <= '0;
            end else begin
                r_state <= w_state_nxt;
                if (w_load) begin
                    r_code <= w_code;
                    r_lp   <= w_lp;
                end
            end
        end

        assign w_conflict[v]                           = w_clash;
        assign rt.route_valid[v]                       = (r_state == ST_ROUTED);
        assign rt.dest_port_coded_all[v*DSTPw +: DSTPw] = r_code;
        assign rt.endp_localp_num_all[v*PLw +: PLw]     = r_lp;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_err         <= 1'b0;
            r_hdr_conflict_err <= 1'b0;
        end else begin
            if (rt.hdr_wr && (|rt.hdr_vc) && !w_valid) r_addr_err <= 1'b1;
            if (|w_conflict) r_hdr_conflict_err <= 1'b1;
        end
    end

    assign rt.addr_err         = r_addr_err;
    assign rt.hdr_conflict_err = r_hdr_conflict_err;
endmodule

// File: tb/tb_fmesh_route_reg.sv
// Scoreboard bench: deterministic and full-adaptive instances share stimulus.
module tb_fmesh_route_reg;
    import pronoc_pkg::*;

    typedef struct {
        int         vc;
        logic [3:0] det;
        logic [3:0] ad;
        logic [2:0] lp;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [Xw-1:0] cur_x = Xw'(1);
    logic [Yw-1:0] cur_y = Yw'(1);
    int vec = 0;
    int miss = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    fmesh_route_reg_if #(.V(4), .DSTPw(4), .PLw(3)) if_d ();
    fmesh_route_reg_if #(.V(4), .DSTPw(4), .PLw(3)) if_a ();

    fmesh_route_reg #(.V(4), .ROUTE_NAME("XY"), .ROUTE_TYPE("DETERMINISTIC"), .DSTPw(4), .PLw(3)) u_det (
        .clk(clk), .reset(reset), .current_x(cur_x), .current_y(cur_y), .rt(if_d));
    fmesh_route_reg #(.V(4), .ROUTE_NAME("ADAPTIVE"), .ROUTE_TYPE("FULL_ADAPTIVE"), .DSTPw(4), .PLw(3)) u_ad (
        .clk(clk), .reset(reset), .current_x(cur_x), .current_y(cur_y), .rt(if_a));

    task automatic drive(input logic wr, input logic [3:0] vcm, input int ex, input int ey, input int ep,
                         input logic [3:0] tail);
        logic [EAw-1:0] a;
        a = {Pw'(ep), Yw'(ey), Xw'(ex)};
        if_d.hdr_wr = wr; if_d.hdr_vc = vcm; if_d.hdr_dest_e_addr = a; if_d.tail_rd = tail;
        if_a.hdr_wr = wr; if_a.hdr_vc = vcm; if_a.hdr_dest_e_addr = a; if_a.tail_rd = tail;
    endtask

    task automatic tick();
        @(posedge clk); #1;
        drive(1'b0, 4'b0, 0, 0, 0, 4'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); reset = 1'b0;
    endtask

    task automatic send_hdr(input int vc, input int ex, input int ey, input int ep, input logic [3:0] tail,
                            input logic [3:0] e_det, input logic [3:0] e_ad, input logic [2:0] e_lp);
        exp_t e;
        drive(1'b1, 4'(1 << vc), ex, ey, ep, tail);
        sb.push_back('{vc, e_det, e_ad, e_lp});
        tick();
        e = sb.pop_front();
        vec++; if (if_d.dest_port_coded_all[e.vc*4 +: 4] !== e.det) begin miss++;
            $display("FAIL code_det vc%0d got %b exp %b", e.vc, if_d.dest_port_coded_all[e.vc*4 +: 4], e.det); end
        vec++; if (if_a.dest_port_coded_all[e.vc*4 +: 4] !== e.ad) begin miss++;
            $display("FAIL code_ad vc%0d got %b exp %b", e.vc, if_a.dest_port_coded_all[e.vc*4 +: 4], e.ad); end
        vec++; if (if_d.endp_localp_num_all[e.vc*3 +: 3] !== e.lp || if_a.endp_localp_num_all[e.vc*3 +: 3] !== e.lp) begin miss++;
            $display("FAIL localp vc%0d got %0d/%0d exp %0d", e.vc, if_d.endp_localp_num_all[e.vc*3 +: 3],
                     if_a.endp_localp_num_all[e.vc*3 +: 3], e.lp); end
        vec++; if (if_d.route_valid[e.vc] !== 1'b1 || if_a.route_valid[e.vc] !== 1'b1) begin miss++;
            $display("FAIL valid vc%0d got %b/%b exp 1", e.vc, if_d.route_valid[e.vc], if_a.route_valid[e.vc]); end
    endtask

    task automatic check_idle(input string name);
        vec++;
        if (if_d.route_valid !== 4'b0 || if_a.route_valid !== 4'b0 || if_d.dest_port_coded_all !== 16'h0 ||
            if_a.dest_port_coded_all !== 16'h0 || if_d.endp_localp_num_all !== 12'h0 ||
            if_d.addr_err !== 1'b0 || if_d.hdr_conflict_err !== 1'b0 || if_a.addr_err !== 1'b0) begin
            miss++;
            $display("FAIL %s valid=%b code=%h lp=%h aerr=%b cerr=%b exp all zero", name, if_d.route_valid,
                     if_d.dest_port_coded_all, if_d.endp_localp_num_all, if_d.addr_err, if_d.hdr_conflict_err);
        end
    endtask

    task automatic test_reset();
        drive(1'b0, 4'b0, 0, 0, 0, 4'b0);
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        check_idle("reset_state");
    endtask

    task automatic test_det_route();
        send_hdr(0, 3, 1, 0, 4'b0, 4'b1010, 4'b1010, 3'd0);
        vec++; if (if_d.route_valid !== 4'b0001) begin miss++;
            $display("FAIL valid_vec got %b exp 0001", if_d.route_valid); end
    endtask

    task automatic test_adaptive();
        send_hdr(1, 3, 3, 0, 4'b0, 4'b1010, 4'b1011, 3'd0);
        send_hdr(3, 1, 0, 0, 4'b0, 4'b0101, 4'b0101, 3'd0);
        vec++; if (if_d.dest_port_coded_all[3:0] !== 4'b1010) begin miss++;
            $display("FAIL vc0_held got %b exp 1010", if_d.dest_port_coded_all[3:0]); end
    endtask

    task automatic test_local();
        send_hdr(2, 1, 1, 3, 4'b0, 4'b0000, 4'b0000, 3'd3);
        drive(1'b0, 4'b0, 0, 0, 0, 4'b0100);
        tick();
        vec++; if (if_d.route_valid !== 4'b1011 || if_a.route_valid !== 4'b1011) begin miss++;
            $display("FAIL tail_drop got %b/%b exp 1011", if_d.route_valid, if_a.route_valid); end
    endtask

    task automatic test_addr_err();
        do_reset();
        send_hdr(0, 2, 2, 6, 4'b0, 4'b0000, 4'b0000, 3'd0);
        vec++; if (if_d.addr_err !== 1'b1 || if_a.addr_err !== 1'b1) begin miss++;
            $display("FAIL addr_err_set got %b/%b exp 1", if_d.addr_err, if_a.addr_err); end
        for (int i = 0; i < 20; i++) tick();
        vec++; if (if_d.addr_err !== 1'b1) begin miss++;
            $display("FAIL addr_err_hold got %b exp 1", if_d.addr_err); end
        do_reset();
        vec++; if (if_d.addr_err !== 1'b0) begin miss++;
            $display("FAIL addr_err_clr got %b exp 0", if_d.addr_err); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_hdr(0, 3, 1, 0, 4'b0, 4'b1010, 4'b1010, 3'd0);
        send_hdr(0, 0, 1, 0, 4'b0001, 4'b0010, 4'b0010, 3'd0);
        vec++; if (if_d.hdr_conflict_err !== 1'b0 || if_a.hdr_conflict_err !== 1'b0) begin miss++;
            $display("FAIL conflict_tail got %b/%b exp 0", if_d.hdr_conflict_err, if_a.hdr_conflict_err); end
        send_hdr(0, 3, 3, 0, 4'b0, 4'b1010, 4'b1011, 3'd0);
        vec++; if (if_d.hdr_conflict_err !== 1'b1 || if_a.hdr_conflict_err !== 1'b1) begin miss++;
            $display("FAIL conflict_set got %b/%b exp 1", if_d.hdr_conflict_err, if_a.hdr_conflict_err); end
    endtask

    task automatic test_reset_all();
        do_reset();
        send_hdr(0, 3, 1, 0, 4'b0, 4'b1010, 4'b1010, 3'd0);
        send_hdr(1, 3, 3, 0, 4'b0, 4'b1010, 4'b1011, 3'd0);
        send_hdr(2, 1, 1, 4, 4'b0, 4'b0000, 4'b0000, 3'd4);
        send_hdr(3, 1, 0, 0, 4'b0, 4'b0101, 4'b0101, 3'd0);
        drive(1'b1, 4'b0, 0, 0, 0, 4'b0);
        tick();
        vec++; if (if_d.route_valid !== 4'b1111 || if_d.dest_port_coded_all !== 16'h50AA) begin miss++;
            $display("FAIL all_routed valid=%b code=%h exp 1111/50aa", if_d.route_valid, if_d.dest_port_coded_all); end
        do_reset();
        check_idle("reset_mid_packet");
        drive(1'b0, 4'b0, 0, 0, 0, 4'b1111);
        tick();
        check_idle("tail_in_idle");
    endtask

    initial begin
        test_reset();
        test_det_route();
        test_adaptive();
        test_local();
        test_addr_err();
        test_back_to_back();
        test_reset_all();
        vec++; if (sb.size() != 0) begin miss++;
            $display("FAIL scoreboard_left got %0d exp 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
